// File: rtl/capture_readout_if.sv
// Read-side buses of the capture readout: sample RAM read port and the upload stream.
// The readout engine is the master of both; the RAM and host uploader sit on the slave side.
interface capture_readout_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/capture_readout.sv
// Drains a finished capture from the circular sample RAM, oldest first: first beat 3 cycles
// after start, at most 1 beat / 3 cycles; a stalled beat is held and no RAM reads are issued.
module capture_readout #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_read,
  input  logic              cap_idle,
  input  logic              abort,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [ADDR_W:0]   sample_count,
  capture_readout_if.master bus,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_SEND, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              start_ok;

  // A simultaneous abort suppresses the start even though abort alone is a no-op in IDLE.
  assign start_ok = start_read & cap_idle & ~abort;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    last_d      = last_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          remaining_d = sample_count;
          // Full buffer (count == depth) wraps back to end_addr itself.
          rd_ptr_d    = end_addr - sample_count[ADDR_W-1:0];
          state_d     = (sample_count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        data_d  = bus.mem_rd_data;
        last_d  = (remaining_q == (ADDR_W+1)'(1));
        state_d = S_SEND;
      end
      S_SEND: begin
        if (bus.out_ready) begin
          if (remaining_q == (ADDR_W+1)'(1)) begin
            state_d = S_DONE;
          end else begin
            remaining_d = remaining_q - (ADDR_W+1)'(1);
            rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
            state_d     = S_READ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      last_q      <= last_d;
    end
  end

  assign bus.mem_rd_en   = (state_q == S_READ);
  assign bus.mem_rd_addr = (state_q == S_READ) ? rd_ptr_q : '0;
  assign bus.out_valid   = (state_q == S_SEND);
  assign bus.out_data    = data_q;
  assign bus.out_last    = last_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);

endmodule

// File: doc/capture_readout.md
Name: capture_readout

Overview:
- Reads a completed capture out of the sample buffer RAM and streams it to the host-side upload path.
- Samples are emitted oldest first over a valid/ready interface.
- It is the read side of the logic capture peripheral: the capture FSM and sample writer fill the circular buffer, and this block drains it once the analyzer is idle.
- One clock domain. The RAM port has a fixed 1-cycle read latency.

Parameters:
ADDR_W, 12, buffer address width; depth = 2^ADDR_W samples
DATA_W, 32, sample width

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-low (block held in reset while reset==0)
start_read  input  1  request readout; single-cycle pulse or level
cap_idle  input  1  capture FSM idle indication; readout permitted only when 1
abort  input  1  cancel readout in progress
end_addr  input  ADDR_W  next-write pointer of the writer (one past newest sample)
sample_count  input  ADDR_W+1  valid samples in buffer, 0..2^ADDR_W
mem_rd_en  output  1  RAM read strobe
mem_rd_addr  output  ADDR_W  RAM read address
mem_rd_data  input  DATA_W  RAM read data, valid the cycle after mem_rd_en
out_valid  output  1  sample valid
out_data  output  DATA_W  sample
out_last  output  1  final sample of capture, qualified by out_valid
out_ready  input  1  consumer accepts when out_valid & out_ready
busy  output  1  readout in progress
done  output  1  one-cycle pulse after the final sample is accepted

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE. All outputs are 0: mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, busy, done. Internal pointer and remaining count are cleared.
- States and outputs:
  - IDLE, READ, WAIT, SEND, DONE.
  - busy=1 in every state except IDLE.
  - mem_rd_en=1 only in READ.
  - out_valid=1 only in SEND.
  - done=1 only in DONE.
- Start acceptance:
  - Accepted only when state==IDLE, start_read==1 and cap_idle==1. Otherwise start_read is ignored; it is not queued.
  - On accept, latch remaining = sample_count and rd_ptr = (end_addr - sample_count) mod 2^ADDR_W, using the low ADDR_W bits.
  - Later changes on end_addr or sample_count are ignored until the next accept.
  - If the latched sample_count==0, go IDLE→DONE: done pulses, no reads, no beats.
  - Otherwise go IDLE→READ.
- READ: mem_rd_en=1, mem_rd_addr=rd_ptr. Next state is WAIT.
- WAIT: register mem_rd_data into out_data. Set out_last = (remaining==1). Next state is SEND.
- SEND:
  - out_valid, out_data and out_last are held stable until out_ready.
  - No RAM reads are issued while stalled.
  - On handshake with remaining==1: go to DONE.
  - On handshake otherwise: remaining -= 1, rd_ptr = rd_ptr+1 mod 2^ADDR_W (wraps 2^ADDR_W-1→0), go to READ.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency:
  - Start accepted at cycle T: mem_rd_en at T+1, first out_valid at T+3.
  - Maximum throughput is 1 sample per 3 cycles.
  - done is asserted the cycle after the final handshake.
- Abort:
  - abort==1 in any state other than IDLE forces IDLE at the next edge.
  - out_valid and busy drop that edge. done is not asserted.
  - If abort and a SEND handshake coincide, the beat counts as transferred, but abort wins and no done is asserted.
  - abort in IDLE has no effect.
  - If start_read and abort are both 1 in IDLE, the start is ignored.
- Full buffer: sample_count==2^ADDR_W gives rd_ptr==end_addr; all 2^ADDR_W locations are read exactly once.
- Reset asserted mid-readout: IDLE the next edge, outputs return to reset values, no done.
- The start_read level held through DONE→IDLE re-accepts on the first IDLE cycle. This is intended: a level request repeats the readout.

Test Plan:
All scenarios use ADDR_W=4 and RAM preloaded with mem[i]=0xA0+i.
1. Basic: end_addr=5, sample_count=3, start pulse with cap_idle=1, out_ready=1 → mem_rd_addr 2,3,4; out_data 0xA2,0xA3,0xA4; out_last only on 0xA4; first out_valid 3 cycles after accept; done one cycle after last handshake.
2. Wrap: end_addr=2, sample_count=5 → addresses 13,14,15,0,1; data 0xAD,0xAE,0xAF,0xA0,0xA1; out_last on 0xA1.
3. Full buffer: end_addr=7, sample_count=16 → 16 beats, addresses 7..15 then 0..6, each exactly once, then a single done pulse.
4. Backpressure: in scenario 1, hold out_ready=0 for 4 cycles while the second beat is valid → out_valid=1, out_data=0xA3 stable, mem_rd_en=0 throughout the stall, sequence otherwise unchanged.
5. Abort and gating:
   - abort after the 2nd handshake of scenario 2 → next cycle out_valid=0, busy=0, done never asserted; a fresh start then reads from the latched start address again.
   - start_read with cap_idle=0 → no busy, no reads.
6. Zero count and reset:
   - sample_count=0 → done pulses 1 cycle after accept, zero beats.
   - reset=0 during the 3rd beat of scenario 3 → all outputs 0 next cycle, no done.
